// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, lock qualification and release of
// the downstream reset on the 12 MHz reference clock. Bounded retries end in a
// bypass/fault state; loss of lock while running re-sequences the PLL.
module pll_lock_supervisor #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 1200,
  parameter int STABLE_CYCLES = 120,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 12
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       locked,
  input  logic       retry,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] lost_count
);

  localparam int RET_W = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [RET_W-1:0]   retries, retries_nx, retries_inc;
  logic [3:0]         lost_nx;
  logic               attempt_fail;
  logic [1:0]         lock_sync;
  logic               locked_s;

  // locked is asynchronous; this two-flop chain is its only sampling point
  always_ff @(posedge clock_in) begin
    if (reset) lock_sync <= 2'b00;
    else       lock_sync <= {lock_sync[0], locked};
  end

  assign locked_s = lock_sync[1];

  // next-state, retry bookkeeping and lock-loss counting
  always_comb begin
    state_nx     = state;
    retries_nx   = retries;
    lost_nx      = lost_count;
    attempt_fail = 1'b0;
    retries_inc  = retries + RET_W'(1);
    unique case (state)
      RESET_PLL: begin
        if (cnt == CNT_W'(RESET_CYCLES - 1)) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s)                             state_nx = STABLE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) attempt_fail = 1'b1;
      end
      STABLE: begin
        // a drop on the completing cycle still counts as a failure
        if (!locked_s) attempt_fail = 1'b1;
        else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_nx   = RUN;
          retries_nx = '0;
        end
      end
      RUN: begin
        // losses while running re-sequence without consuming retries
        if (!locked_s) begin
          state_nx = RESET_PLL;
          if (lost_count != 4'hF) lost_nx = lost_count + 4'd1;
        end
      end
      FAULT: begin
        if (retry) begin
          state_nx   = RESET_PLL;
          retries_nx = '0;
        end
      end
      default: state_nx = RESET_PLL;
    endcase
    if (attempt_fail) begin
      retries_nx = retries_inc;
      state_nx   = (retries_inc == RET_W'(MAX_RETRIES)) ? FAULT : RESET_PLL;
    end
  end

  // state, retry and lost-lock registers
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= RESET_PLL;
      retries    <= '0;
      lost_count <= 4'd0;
    end else begin
      state      <= state_nx;
      retries    <= retries_nx;
      lost_count <= lost_nx;
    end
  end

  // phase counter: restarts on every state change, idles in RUN and FAULT
  always_ff @(posedge clock_in) begin
    if (reset)                                       cnt <= '0;
    else if (state_nx != state)                      cnt <= '0;
    else if (state == RESET_PLL || state == WAIT_LOCK ||
             state == STABLE)                        cnt <= cnt + CNT_W'(1);
  end

  // outputs decoded from the next state so they move with the state register
  always_ff @(posedge clock_in) begin
    if (reset) begin
      pll_resetb <= 1'b0;
      pll_bypass <= 1'b0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pll_resetb <= !(state_nx == RESET_PLL || state_nx == FAULT);
      pll_bypass <= (state_nx == FAULT);
      sys_reset  <= (state_nx != RUN);
      ready      <= (state_nx == RUN);
      fault      <= (state_nx == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scenario tasks push expected output snapshots keyed
// by edge number (edge 0 = last edge with reset high) and pop/compare them at
// the negedge following that edge.
module tb_pll_lock_supervisor;

  localparam int RC = 4, LT = 20, SC = 8, MR = 3;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       locked   = 1'b0;
  logic       retry    = 1'b0;
  logic       pll_resetb, pll_bypass, sys_reset, ready, fault;
  logic [3:0] lost_count;

  pll_lock_supervisor #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .CNT_W(12)
  ) dut (
    .clock_in(clock_in), .reset(reset), .locked(locked), .retry(retry),
    .pll_resetb(pll_resetb), .pll_bypass(pll_bypass), .sys_reset(sys_reset),
    .ready(ready), .fault(fault), .lost_count(lost_count)
  );

  always #5 clock_in = ~clock_in;

  // state encodings as the bench expects them
  localparam logic [2:0] S_RST = 3'd0, S_WAIT = 3'd1, S_STB = 3'd2, S_RUN = 3'd3, S_FLT = 3'd4;

  typedef struct {
    string      name;
    int         t;
    logic [2:0] st;
    logic [1:0] rt;
    logic [8:0] outs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0;

  logic [8:0] obs;
  logic [2:0] st_obs;
  logic [1:0] rt_obs;
  assign obs    = {pll_resetb, pll_bypass, sys_reset, ready, fault, lost_count};
  assign st_obs = dut.state;
  assign rt_obs = dut.retries;

  // expected output vectors {resetb, bypass, sys_reset, ready, fault, lost}
  function automatic logic [8:0] o_rst(logic [3:0] lc); return {5'b00100, lc}; endfunction
  function automatic logic [8:0] o_act(logic [3:0] lc); return {5'b10100, lc}; endfunction
  function automatic logic [8:0] o_run(logic [3:0] lc); return {5'b10010, lc}; endfunction
  function automatic logic [8:0] o_flt(logic [3:0] lc); return {5'b01101, lc}; endfunction

  task automatic push(string n, int t, logic [2:0] st, logic [1:0] rt, logic [8:0] o);
    exp_t e;
    e.name = n; e.t = t; e.st = st; e.rt = rt; e.outs = o;
    sb.push_back(e);
  endtask

  // structural invariants on every cycle once out of the first reset
  always @(negedge clock_in) begin
    if (mon_en) begin
      checks++;
      if ((pll_bypass && ready) || (!sys_reset && !ready)) begin
        failures++;
        $display("FAIL invariant: bypass=%b ready=%b sys_reset=%b (need !(bypass&ready) and sys_reset|ready)",
                 pll_bypass, ready, sys_reset);
      end
    end
  end

  task automatic test_reset();
    exp_t e;
    @(negedge clock_in);
    reset = 1'b1; locked = 1'b1; retry = 1'b1;
    repeat (3) @(negedge clock_in);
    push("reset_outs", 0, S_RST, 2'd0, o_rst(4'd0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e.outs || st_obs !== e.st || rt_obs !== e.rt) begin
        failures++;
        $display("FAIL %s: got st=%0d rt=%0d outs=%b, want st=%0d rt=%0d outs=%b",
                 e.name, st_obs, rt_obs, obs, e.st, e.rt, e.outs);
      end
    end
    checks++;
    if (dut.cnt !== 12'd0 || dut.lock_sync !== 2'b00) begin
      failures++;
      $display("FAIL reset_cnt_sync: got cnt=%0d sync=%b, want cnt=0 sync=00", dut.cnt, dut.lock_sync);
    end
    reset = 1'b0; retry = 1'b0; locked = 1'b0;
    @(negedge clock_in);
    mon_en = 1'b1;
  endtask

  task automatic test_nominal();
    exp_t e;
    @(negedge clock_in); reset = 1'b1; retry = 1'b0; locked = 1'b0;
    @(negedge clock_in); reset = 1'b0;
    push("nom_t0",  0,  S_RST,  2'd0, o_rst(4'd0));
    push("nom_t3",  3,  S_RST,  2'd0, o_rst(4'd0));
    push("nom_t4",  4,  S_WAIT, 2'd0, o_act(4'd0));
    push("nom_t8",  8,  S_WAIT, 2'd0, o_act(4'd0));
    push("nom_t9",  9,  S_STB,  2'd0, o_act(4'd0));
    push("nom_t16", 16, S_STB,  2'd0, o_act(4'd0));
    push("nom_t17", 17, S_RUN,  2'd0, o_run(4'd0));
    push("nom_t20", 20, S_RUN,  2'd0, o_run(4'd0));
    for (int t = 0; t <= 21; t++) begin
      if (t > 0) @(negedge clock_in);
      while (sb.size() > 0 && sb[0].t <= t) begin
        e = sb.pop_front(); checks++;
        if (e.t != t || obs !== e.outs || st_obs !== e.st || rt_obs !== e.rt) begin
          failures++;
          $display("FAIL %s t=%0d: got st=%0d rt=%0d outs=%b, want st=%0d rt=%0d outs=%b",
                   e.name, e.t, st_obs, rt_obs, obs, e.st, e.rt, e.outs);
        end
      end
      locked = (t >= 6);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++; failures++;
      $display("FAIL %s t=%0d: expectation never sampled", e.name, e.t);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    @(negedge clock_in); reset = 1'b1; retry = 1'b0; locked = 1'b0;
    @(negedge clock_in); reset = 1'b0;
    push("gl_t0",  0,  S_RST,  2'd0, o_rst(4'd0));
    push("gl_t4",  4,  S_WAIT, 2'd0, o_act(4'd0));
    push("gl_t9",  9,  S_STB,  2'd0, o_act(4'd0));
    push("gl_t14", 14, S_STB,  2'd0, o_act(4'd0));
    push("gl_t15", 15, S_RST,  2'd1, o_rst(4'd0));
    push("gl_t18", 18, S_RST,  2'd1, o_rst(4'd0));
    push("gl_t19", 19, S_WAIT, 2'd1, o_act(4'd0));
    push("gl_t20", 20, S_STB,  2'd1, o_act(4'd0));
    push("gl_t27", 27, S_STB,  2'd1, o_act(4'd0));
    push("gl_t28", 28, S_RUN,  2'd0, o_run(4'd0));
    for (int t = 0; t <= 30; t++) begin
      if (t > 0) @(negedge clock_in);
      while (sb.size() > 0 && sb[0].t <= t) begin
        e = sb.pop_front(); checks++;
        if (e.t != t || obs !== e.outs || st_obs !== e.st || rt_obs !== e.rt) begin
          failures++;
          $display("FAIL %s t=%0d: got st=%0d rt=%0d outs=%b, want st=%0d rt=%0d outs=%b",
                   e.name, e.t, st_obs, rt_obs, obs, e.st, e.rt, e.outs);
        end
      end
      locked = (t >= 6) && (t != 12);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++; failures++;
      $display("FAIL %s t=%0d: expectation never sampled", e.name, e.t);
    end
  endtask

  task automatic test_timeout_fault();
    exp_t e;
    @(negedge clock_in); reset = 1'b1; retry = 1'b0; locked = 1'b0;
    @(negedge clock_in); reset = 1'b0;
    push("to_t3",  3,  S_RST,  2'd0, o_rst(4'd0));
    push("to_t4",  4,  S_WAIT, 2'd0, o_act(4'd0));
    push("to_t11", 11, S_WAIT, 2'd0, o_act(4'd0));
    push("to_t23", 23, S_WAIT, 2'd0, o_act(4'd0));
    push("to_t24", 24, S_RST,  2'd1, o_rst(4'd0));
    push("to_t27", 27, S_RST,  2'd1, o_rst(4'd0));
    push("to_t28", 28, S_WAIT, 2'd1, o_act(4'd0));
    push("to_t47", 47, S_WAIT, 2'd1, o_act(4'd0));
    push("to_t48", 48, S_RST,  2'd2, o_rst(4'd0));
    push("to_t52", 52, S_WAIT, 2'd2, o_act(4'd0));
    push("to_t71", 71, S_WAIT, 2'd2, o_act(4'd0));
    push("to_t72", 72, S_FLT,  2'd3, o_flt(4'd0));
    push("to_t80", 80, S_FLT,  2'd3, o_flt(4'd0));
    push("to_t81", 81, S_RST,  2'd0, o_rst(4'd0));
    push("to_t84", 84, S_RST,  2'd0, o_rst(4'd0));
    push("to_t85", 85, S_WAIT, 2'd0, o_act(4'd0));
    for (int t = 0; t <= 86; t++) begin
      if (t > 0) @(negedge clock_in);
      while (sb.size() > 0 && sb[0].t <= t) begin
        e = sb.pop_front(); checks++;
        if (e.t != t || obs !== e.outs || st_obs !== e.st || rt_obs !== e.rt) begin
          failures++;
          $display("FAIL %s t=%0d: got st=%0d rt=%0d outs=%b, want st=%0d rt=%0d outs=%b",
                   e.name, e.t, st_obs, rt_obs, obs, e.st, e.rt, e.outs);
        end
      end
      // retry at edge 10 lands in WAIT_LOCK and must be ignored
      retry = (t == 9) || (t == 80);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++; failures++;
      $display("FAIL %s t=%0d: expectation never sampled", e.name, e.t);
    end
  endtask

  task automatic test_run_loss();
    exp_t e;
    int   td;
    logic [3:0] lb, la;
    @(negedge clock_in); reset = 1'b1; retry = 1'b0; locked = 1'b0;
    @(negedge clock_in); reset = 1'b0;
    push("rl_t17", 17, S_RUN, 2'd0, o_run(4'd0));
    for (int i = 0; i < 17; i++) begin
      td = 20 + 20 * i;
      lb = (i     > 15) ? 4'd15 : 4'(i);
      la = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      push($sformatf("rl%0d_run",   i), td + 2,  S_RUN,  2'd0, o_run(lb));
      push($sformatf("rl%0d_drop",  i), td + 3,  S_RST,  2'd0, o_rst(la));
      push($sformatf("rl%0d_wait",  i), td + 7,  S_WAIT, 2'd0, o_act(la));
      push($sformatf("rl%0d_stb",   i), td + 8,  S_STB,  2'd0, o_act(la));
      push($sformatf("rl%0d_stb2",  i), td + 15, S_STB,  2'd0, o_act(la));
      push($sformatf("rl%0d_rerun", i), td + 16, S_RUN,  2'd0, o_run(la));
    end
    for (int t = 0; t <= 20 + 20 * 17; t++) begin
      if (t > 0) @(negedge clock_in);
      while (sb.size() > 0 && sb[0].t <= t) begin
        e = sb.pop_front(); checks++;
        if (e.t != t || obs !== e.outs || st_obs !== e.st || rt_obs !== e.rt) begin
          failures++;
          $display("FAIL %s t=%0d: got st=%0d rt=%0d outs=%b, want st=%0d rt=%0d outs=%b",
                   e.name, e.t, st_obs, rt_obs, obs, e.st, e.rt, e.outs);
        end
      end
      locked = (t >= 6) && !(t >= 20 && ((t - 20) % 20) == 0);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++; failures++;
      $display("FAIL %s t=%0d: expectation never sampled", e.name, e.t);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clock_in); reset = 1'b1; retry = 1'b0; locked = 1'b0;
    @(negedge clock_in); reset = 1'b0;
    push("rm_t0",  0,  S_RST,  2'd0, o_rst(4'd0));
    push("rm_t9",  9,  S_STB,  2'd0, o_act(4'd0));
    push("rm_t12", 12, S_STB,  2'd0, o_act(4'd0));
    push("rm_t13", 13, S_RST,  2'd0, o_rst(4'd0));
    push("rm_t16", 16, S_RST,  2'd0, o_rst(4'd0));
    push("rm_t17", 17, S_WAIT, 2'd0, o_act(4'd0));
    push("rm_t85", 85, S_FLT,  2'd3, o_flt(4'd0));
    push("rm_t90", 90, S_FLT,  2'd3, o_flt(4'd0));
    push("rm_t91", 91, S_RST,  2'd0, o_rst(4'd0));
    push("rm_t94", 94, S_RST,  2'd0, o_rst(4'd0));
    push("rm_t95", 95, S_WAIT, 2'd0, o_act(4'd0));
    for (int t = 0; t <= 96; t++) begin
      if (t > 0) @(negedge clock_in);
      while (sb.size() > 0 && sb[0].t <= t) begin
        e = sb.pop_front(); checks++;
        if (e.t != t || obs !== e.outs || st_obs !== e.st || rt_obs !== e.rt) begin
          failures++;
          $display("FAIL %s t=%0d: got st=%0d rt=%0d outs=%b, want st=%0d rt=%0d outs=%b",
                   e.name, e.t, st_obs, rt_obs, obs, e.st, e.rt, e.outs);
        end
      end
      if (t == 13 || t == 91) begin
        checks++;
        if (dut.cnt !== 12'd0 || dut.lock_sync !== 2'b00) begin
          failures++;
          $display("FAIL rm_cnt_sync t=%0d: got cnt=%0d sync=%b, want cnt=0 sync=00",
                   t, dut.cnt, dut.lock_sync);
        end
      end
      // locked stays high through the mid-STABLE reset, then never returns
      locked = (t >= 6) && (t < 13);
      reset  = (t == 12) || (t == 90);
      retry  = (t == 90);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++; failures++;
      $display("FAIL %s t=%0d: expectation never sampled", e.name, e.t);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout_fault();
    test_run_loss();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequencer for the iCE40 transmit PLL: holds the PLL in reset after power-up, waits for lock, qualifies lock as stable, then releases the downstream system reset. Re-sequences on loss of lock, retries a bounded number of times, and falls back to PLL bypass with a fault flag when the PLL never qualifies. Runs entirely on the 12 MHz reference clock and sits between the board oscillator, the SB_PLL40_CORE wrapper, and the reset tree of the high-speed modulator domain.

## Interface
- RESET_CYCLES, 16: cycles PLL RESETB is held low per attempt (≥2).
- LOCK_TIMEOUT, 1200: cycles allowed for first lock assertion per attempt (100 µs at 12 MHz).
- STABLE_CYCLES, 120: consecutive synchronized-lock cycles required before release (10 µs).
- MAX_RETRIES, 3: failed attempts before entering FAULT (≥1).
- CNT_W, 12: phase counter width; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

- clock_in  input  1  12 MHz reference clock; the only clock.
- reset  input  1  synchronous, active-high.
- locked  input  1  PLL LOCK, asynchronous to clock_in.
- retry  input  1  single-cycle pulse; restarts sequencing from FAULT.
- pll_resetb  output  1  to PLL RESETB; active-low.
- pll_bypass  output  1  to PLL BYPASS; high only in FAULT.
- sys_reset  output  1  downstream reset, active-high.
- ready  output  1  PLL qualified and running.
- fault  output  1  retries exhausted.
- lost_count  output  4  saturating count of lock losses while in RUN.

## Operation
- locked passes through a 2-flop synchronizer → locked_s; nothing else samples locked.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT. One phase counter, cleared on every state change.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- Reset (priority over everything): state=RESET_PLL, counter=0, retries=0, lost_count=0, pll_resetb=0, pll_bypass=0, sys_reset=1, ready=0, fault=0; synchronizer flops cleared to 0.
- RESET_PLL: pll_resetb=0, sys_reset=1. After RESET_CYCLES cycles in state → WAIT_LOCK.
- WAIT_LOCK: pll_resetb=1. locked_s=1 → STABLE. Counter reaches LOCK_TIMEOUT−1 with locked_s=0 → attempt failure.
- STABLE: locked_s=0 on any cycle → attempt failure. STABLE_CYCLES consecutive cycles with locked_s=1 → RUN; retries cleared.
- Attempt failure: retries+1; if the new value equals MAX_RETRIES → FAULT, else → RESET_PLL.
- RUN: sys_reset=0, ready=1. locked_s=0 → RESET_PLL (sys_reset=1, ready=0 on that edge), lost_count+1, saturating at 15. Retries are not incremented for losses in RUN.
- FAULT: pll_resetb=0, pll_bypass=1, fault=1, sys_reset=1. Terminal until reset or retry. retry=1 → RESET_PLL with retries=0, fault=0, bypass=0. retry is ignored in all other states.
- Simultaneous reset and retry: reset wins. locked_s falling on the same cycle STABLE completes: failure wins, no RUN.

## Timing
- Reset released at edge 0: pll_resetb rises at edge RESET_CYCLES.
- locked rising, first sampled at edge k: locked_s=1 after edge k+1; STABLE entered at edge k+2; RUN (sys_reset=0, ready=1) at edge k+2+STABLE_CYCLES.
- Lock loss sampled at edge k in RUN: sys_reset=1 at edge k+2. Worst-case reset reassertion latency is 3 reference cycles (250 ns).
- Timeout: with no lock, WAIT_LOCK lasts exactly LOCK_TIMEOUT cycles. Each failed attempt costs RESET_CYCLES+LOCK_TIMEOUT cycles.
- sys_reset never deasserts unless ready asserts on the same edge. pll_bypass and ready are never high together.

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3.
- Nominal: reset, locked rises 3 cycles after pll_resetb rises → pll_resetb rises at edge 4; STABLE at edge 9; sys_reset=0 and ready=1 at edge 17; lost_count=0.
- Glitch in STABLE: locked low for 1 cycle after 5 cycles of STABLE → back to RESET_PLL; retries=1; then clean lock reaches RUN and retries reads 0.
- No lock ever: exactly 3 attempts of 4+20 cycles → FAULT at edge 72 with fault=1, pll_bypass=1, pll_resetb=0, sys_reset=1. Retry pulse → RESET_PLL with fault=0.
- Loss in RUN ×17: sys_reset=1 two edges after each drop, re-qualifies each time; lost_count saturates at 15; fault stays 0.
- Reset mid-STABLE, plus reset and retry asserted together in FAULT: all outputs return to reset values on the next edge; state=RESET_PLL; counter=0.
